// File: rtl/seq_pkg.sv
// Shared definitions for the sequence-detector front end: state encoding and
// default word width / idle level.
package seq_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int   DEF_WIDTH    = 8;
    localparam logic DEF_IDLE_BIT = 1'b1;

endpackage

// File: rtl/seq_serializer_if.sv
// Load handshake plus serial output bundle of the serializer.
// slave = serializer side, master = producer / detector side.
interface seq_serializer_if
    import seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] data_in;
    logic             load_valid;
    logic             load_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             word_done;
    logic             busy;

    modport master (
        output data_in, load_valid,
        input  load_ready, ser_out, ser_valid, word_done, busy
    );

    modport slave (
        input  data_in, load_valid,
        output load_ready, ser_out, ser_valid, word_done, busy
    );
endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: one WIDTH-bit word in, one bit per clock out.
// Define SER_PRELOAD_EN to accept the next word on the last-bit cycle (zero gap).
module seq_serializer
    import seq_pkg::*;
#(
    parameter int   WIDTH     = DEF_WIDTH,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = DEF_IDLE_BIT
) (
    input  logic            clock,
    input  logic            reset,
    seq_serializer_if.slave bus
);
    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    state_e            r_state, w_state_nx;
    logic [WIDTH-1:0]  r_shreg, w_shreg_nx, w_shifted;
    logic [CW-1:0]     r_cnt, w_cnt_nx;
    logic              w_ready, w_accept, w_out_bit;

    assign w_out_bit = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
    assign w_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                                 : {1'b0, r_shreg[WIDTH-1:1]};

`ifdef SER_PRELOAD_EN
    assign w_ready = (r_state == ST_IDLE) || (r_cnt == '0);
`else
    assign w_ready = (r_state == ST_IDLE);
`endif
    assign w_accept = bus.load_valid && w_ready && !reset;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_shreg <= w_shreg_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // A load on the last-bit edge overrides the shift, so preload needs no extra branch.
    always_comb begin
        w_state_nx = r_state;
        w_shreg_nx = r_shreg;
        w_cnt_nx   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_shreg_nx = bus.data_in;
                    w_cnt_nx   = CNT_LAST;
                    w_state_nx = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_shreg_nx = w_shifted;
                if (r_cnt != '0) begin
                    w_cnt_nx = r_cnt - CW'(1);
                end else if (w_accept) begin
                    w_shreg_nx = bus.data_in;
                    w_cnt_nx   = CNT_LAST;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    assign bus.busy       = (r_state == ST_SHIFT);
    assign bus.ser_valid  = (r_state == ST_SHIFT);
    assign bus.ser_out    = (r_state == ST_SHIFT) ? w_out_bit : IDLE_BIT;
    assign bus.word_done  = (r_state == ST_SHIFT) && (r_cnt == '0);
    assign bus.load_ready = w_ready && !reset;

endmodule

// File: tb/tb_seq_serializer.sv
// Scoreboard bench: an MSB-first and an LSB-first serializer share one stimulus
// stream; a word-level model predicts bits, readiness and gaps.
module tb_seq_serializer;
    localparam int   W        = 8;
    localparam logic IDLE_BIT = 1'b1;
`ifdef SER_PRELOAD_EN
    localparam bit PRELOAD = 1'b1;
`else
    localparam bit PRELOAD = 1'b0;
`endif

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] data_in = '0;
    logic         load_valid = 1'b0;

    int   n_chk = 0;
    int   n_pass = 0;
    exp_t qm[$];
    exp_t ql[$];
    int   rem = 0;
    int   cyc = 0;
    int   acc_cnt = 0;
    int   acc_cyc = 0;
    int   acc_prev = 0;

    seq_serializer_if #(.WIDTH(W)) if_m ();
    seq_serializer_if #(.WIDTH(W)) if_l ();

    assign if_m.data_in    = data_in;
    assign if_m.load_valid = load_valid;
    assign if_l.data_in    = data_in;
    assign if_l.load_valid = load_valid;

    seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE_BIT)) u_msb (
        .clock (clock),
        .reset (reset),
        .bus   (if_m.slave)
    );

    seq_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE_BIT)) u_lsb (
        .clock (clock),
        .reset (reset),
        .bus   (if_l.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    endtask

    // Word-level reference: a word occupies W cycles after its accept; the
    // producer may hand over when nothing (or, with preload, only the last bit) remains.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            rem <= 0;
            qm.delete();
            ql.delete();
        end else begin
            bit rdy;
            rdy = PRELOAD ? (rem <= 1) : (rem == 0);
            cyc <= cyc + 1;
            if (rdy && load_valid) begin
                for (int i = 0; i < W; i++) begin
                    qm.push_back('{b: data_in[W-1-i], last: (i == W-1)});
                    ql.push_back('{b: data_in[i],     last: (i == W-1)});
                end
                rem      <= W;
                acc_cnt  <= acc_cnt + 1;
                acc_prev <= acc_cyc;
                acc_cyc  <= cyc;
            end else if (rem > 0) begin
                rem <= rem - 1;
            end
        end
    end

    task automatic check_dut(input string tag, input logic rdy, input logic so,
                             input logic sv, input logic wd, input logic bz,
                             input bit have, input exp_t e);
        bit exp_rdy;
        exp_rdy = PRELOAD ? (rem <= 1) : (rem == 0);
        chk({tag, ".load_ready"}, int'(rdy), int'(exp_rdy));
        chk({tag, ".ser_valid"}, int'(sv), int'(rem > 0));
        chk({tag, ".busy"}, int'(bz), int'(rem > 0));
        if (rem > 0) begin
            chk({tag, ".queue_nonempty"}, int'(have), 1);
            if (have) begin
                chk({tag, ".ser_out"}, int'(so), int'(e.b));
                chk({tag, ".word_done"}, int'(wd), int'(e.last));
            end
        end else begin
            chk({tag, ".idle_level"}, int'(so), int'(IDLE_BIT));
            chk({tag, ".word_done_idle"}, int'(wd), 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".rst_ser_out_m"}, int'(if_m.ser_out), int'(IDLE_BIT));
        chk({tag, ".rst_ser_valid_m"}, int'(if_m.ser_valid), 0);
        chk({tag, ".rst_busy_m"}, int'(if_m.busy), 0);
        chk({tag, ".rst_word_done_m"}, int'(if_m.word_done), 0);
        chk({tag, ".rst_load_ready_m"}, int'(if_m.load_ready), 0);
        chk({tag, ".rst_ser_out_l"}, int'(if_l.ser_out), int'(IDLE_BIT));
        chk({tag, ".rst_ser_valid_l"}, int'(if_l.ser_valid), 0);
        chk({tag, ".rst_word_done_l"}, int'(if_l.word_done), 0);
    endtask

    // Monitor: samples on the falling edge, decoupled from the driver.
    always @(negedge clock) begin
        if (reset) begin
            check_reset_outputs("reset");
        end else begin
            exp_t em, el;
            bit   hm, hl;
            em = '0; el = '0; hm = 1'b0; hl = 1'b0;
            if (rem > 0) begin
                if (qm.size() > 0) begin em = qm.pop_front(); hm = 1'b1; end
                if (ql.size() > 0) begin el = ql.pop_front(); hl = 1'b1; end
            end
            check_dut("msb", if_m.load_ready, if_m.ser_out, if_m.ser_valid,
                      if_m.word_done, if_m.busy, hm, em);
            check_dut("lsb", if_l.load_ready, if_l.ser_out, if_l.ser_valid,
                      if_l.word_done, if_l.busy, hl, el);
        end
    end

    // Offer a word until the model accepts it; optionally keep valid high for a
    // following word, or wiggle data_in/load_valid while the word is in flight.
    task automatic send(input logic [W-1:0] w, input bit hold, input bit junk);
        int start;
        data_in    = w;
        load_valid = 1'b1;
        start      = acc_cnt;
        for (int k = 0; k < 100 && acc_cnt == start; k++) @(negedge clock);
        if (acc_cnt == start) chk("accept_timeout", 0, 1);
        if (junk) begin
            for (int k = 0; k < 4 * W && rem > 1; k++) begin
                load_valid = 1'($urandom_range(0, 1));
                data_in    = W'($urandom);
                @(negedge clock);
            end
            load_valid = 1'b0;
        end else if (!hold) begin
            load_valid = 1'b0;
        end
    endtask

    task automatic drain();
        load_valid = 1'b0;
        for (int k = 0; k < 4 * W && rem > 0; k++) @(negedge clock);
        chk("drain_timeout", int'(rem == 0), 1);
        @(negedge clock);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        send(8'h1E, 1'b0, 1'b0);
        drain();

        send(8'hF0, 1'b1, 1'b0);
        send(8'h01, 1'b0, 1'b0);
        chk("b2b_accept_spacing", acc_cyc - acc_prev, PRELOAD ? W : W + 1);
        drain();

        // Abort while bit 4 of 0xA5 is on the line.
        send(8'hA5, 1'b0, 1'b0);
        repeat (3) @(negedge clock);
        #1 reset = 1'b1;
        #1 check_reset_outputs("midword");
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        send(8'h3C, 1'b0, 1'b1);
        drain();

        for (int n = 0; n < 30; n++) begin
            bit hold;
            hold = 1'($urandom_range(0, 1));
            send(W'($urandom), hold, hold ? 1'b0 : 1'($urandom_range(0, 1)));
            if (!hold) repeat ($urandom_range(0, 3)) @(negedge clock);
        end
        drain();
        chk("queue_m_empty", qm.size(), 0);
        chk("queue_l_empty", ql.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
